// File: rtl/sdram_arb_pkg.sv
// Purpose: shared types and default sizes for the two-master SDRAM port arbiter.
// Contents: master_id_t (which master owns a transfer), master count,
//           default address/data widths and read-tag depth.
package sdram_arb_pkg;

    typedef logic master_id_t;

    localparam int unsigned NUM_MASTERS  = 2;
    localparam int unsigned ADDR_W_DEF   = 22;
    localparam int unsigned DATA_W_DEF   = 16;
    localparam int unsigned MAX_PEND_DEF = 4;

    localparam master_id_t M0 = 1'b0;
    localparam master_id_t M1 = 1'b1;

endpackage

// File: rtl/arb_tag_fifo.sv
// Purpose: small synchronous FIFO of master IDs, one entry per outstanding read,
//          so each read response can be routed back to its issuing master.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_push, i_push_id write an ID at the tail (ignored when full)
//   i_pop             drop the head entry (ignored when empty)
//   o_head            ID at the head of the queue
//   o_count           occupancy, 0..DEPTH
//   o_full, o_empty   occupancy flags
module arb_tag_fifo
    import sdram_arb_pkg::*;
#(
    parameter int unsigned DEPTH = MAX_PEND_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_push,
    input  master_id_t                   i_push_id,
    input  logic                         i_pop,
    output master_id_t                   o_head,
    output logic [$clog2(DEPTH):0]       o_count,
    output logic                         o_full,
    output logic                         o_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    master_id_t       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= M0;
            end
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= i_push_id;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Purpose: round-robin arbiter sharing one SDRAM controller Avalon-MM slave
//          between two masters, with zero-latency command forwarding and
//          tag-FIFO routing of pipelined read responses.
// Ports:
//   clk_clk, reset_reset_n              clock, asynchronous active-low reset
//   m0_*, m1_*                          Avalon-MM master-side ports
//   s_*                                 command to / response from the controller
//   err_unexpected_rdv                  sticky: readdatavalid with no read pending
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned MAX_PEND = MAX_PEND_DEF
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset_n,

    input  logic [ADDR_W-1:0]     m0_address,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_writedata,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic                  m0_readdatavalid,

    input  logic [ADDR_W-1:0]     m1_address,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  m1_readdatavalid,

    output logic [ADDR_W-1:0]     s_address,
    output logic                  s_read,
    output logic                  s_write,
    output logic [DATA_W-1:0]     s_writedata,
    output logic [DATA_W/8-1:0]   s_byteenable,
    input  logic                  s_waitrequest,
    input  logic [DATA_W-1:0]     s_readdata,
    input  logic                  s_readdatavalid,

    output logic                  err_unexpected_rdv
);

    localparam int unsigned PEND_W = $clog2(MAX_PEND) + 1;

    master_id_t        r_rr;
    logic              r_lock;
    master_id_t        r_lock_id;
    logic              r_err;

    logic              w_req0;
    logic              w_req1;
    logic              w_elig0;
    logic              w_elig1;
    logic              w_gnt_vld;
    master_id_t        w_gnt_id;
    logic              w_cmd;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    master_id_t        w_head;
    logic [PEND_W-1:0] w_pend_cnt;
    logic              w_full;
    logic              w_empty;

    assign w_req0  = m0_read | m0_write;
    assign w_req1  = m1_read | m1_write;
    // Reads are throttled by the registered count only, so a pop frees a slot
    // one cycle later (no same-cycle bypass).
    assign w_elig0 = m0_write | (m0_read & ~w_full);
    assign w_elig1 = m1_write | (m1_read & ~w_full);

    // Grant: a stalled command keeps its grant; otherwise round-robin on ties.
    always_comb begin
        w_gnt_id  = r_rr;
        w_gnt_vld = 1'b0;
        if (r_lock) begin
            w_gnt_id  = r_lock_id;
            w_gnt_vld = (r_lock_id == M1) ? w_req1 : w_req0;
        end else if (w_elig0 && w_elig1) begin
            w_gnt_id  = r_rr;
            w_gnt_vld = 1'b1;
        end else if (w_elig0) begin
            w_gnt_id  = M0;
            w_gnt_vld = 1'b1;
        end else if (w_elig1) begin
            w_gnt_id  = M1;
            w_gnt_vld = 1'b1;
        end
    end

    // Command mux toward the controller.
    always_comb begin
        s_address    = m0_address;
        s_writedata  = m0_writedata;
        s_byteenable = m0_byteenable;
        s_read       = 1'b0;
        s_write      = 1'b0;
        if (w_gnt_id == M1) begin
            s_address    = m1_address;
            s_writedata  = m1_writedata;
            s_byteenable = m1_byteenable;
        end
        if (w_gnt_vld) begin
            s_read  = (w_gnt_id == M1) ? m1_read  : m0_read;
            s_write = (w_gnt_id == M1) ? m1_write : m0_write;
        end
    end

    assign w_cmd    = s_read | s_write;
    assign w_accept = w_cmd & ~s_waitrequest;
    assign w_push   = w_accept & s_read;
    assign w_pop    = s_readdatavalid & ~w_empty;

    assign m0_waitrequest = ~(w_gnt_vld && (w_gnt_id == M0)) | s_waitrequest;
    assign m1_waitrequest = ~(w_gnt_vld && (w_gnt_id == M1)) | s_waitrequest;

    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;
    assign m0_readdatavalid = w_pop & (w_head == M0);
    assign m1_readdatavalid = w_pop & (w_head == M1);

    assign err_unexpected_rdv = r_err;

    // Round-robin pointer, stall lock and sticky error flag.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_rr      <= M0;
            r_lock    <= 1'b0;
            r_lock_id <= M0;
            r_err     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_rr <= master_id_t'(~w_gnt_id);
            end
            r_lock <= w_cmd & s_waitrequest;
            if (w_cmd && s_waitrequest) begin
                r_lock_id <= w_gnt_id;
            end
            if (s_readdatavalid && w_empty) begin
                r_err <= 1'b1;
            end
        end
    end

    arb_tag_fifo #(
        .DEPTH (MAX_PEND)
    ) u_tag_fifo (
        .clk       (clk_clk),
        .rst_n     (reset_reset_n),
        .i_push    (w_push),
        .i_push_id (w_gnt_id),
        .i_pop     (w_pop),
        .o_head    (w_head),
        .o_count   (w_pend_cnt),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Purpose: directed self-checking bench for sdram_port_arbiter; read responses
//          are checked against a queue of expected owning masters.
module tb_sdram_port_arbiter;
    import sdram_arb_pkg::*;

    localparam int unsigned AW = 22;
    localparam int unsigned DW = 16;
    localparam int unsigned BW = DW / 8;
    localparam int unsigned MP = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] m0_address = '0, m1_address = '0;
    logic          m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
    logic [DW-1:0] m0_writedata = '0, m1_writedata = '0;
    logic [BW-1:0] m0_byteenable = '1, m1_byteenable = '1;
    logic          m0_waitrequest, m1_waitrequest;
    logic [DW-1:0] m0_readdata, m1_readdata;
    logic          m0_readdatavalid, m1_readdatavalid;
    logic [AW-1:0] s_address;
    logic          s_read, s_write;
    logic [DW-1:0] s_writedata;
    logic [BW-1:0] s_byteenable;
    logic          s_waitrequest = 1'b0;
    logic [DW-1:0] s_readdata = '0;
    logic          s_readdatavalid = 1'b0;
    logic          err_unexpected_rdv;

    int unsigned   n_tests = 0;
    int unsigned   n_fail  = 0;
    master_id_t    exp_q[$];

    always #5 clk = ~clk;

    sdram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_PEND(MP)) dut (
        .clk_clk            (clk),
        .reset_reset_n      (rst_n),
        .m0_address         (m0_address),
        .m0_read            (m0_read),
        .m0_write           (m0_write),
        .m0_writedata       (m0_writedata),
        .m0_byteenable      (m0_byteenable),
        .m0_waitrequest     (m0_waitrequest),
        .m0_readdata        (m0_readdata),
        .m0_readdatavalid   (m0_readdatavalid),
        .m1_address         (m1_address),
        .m1_read            (m1_read),
        .m1_write           (m1_write),
        .m1_writedata       (m1_writedata),
        .m1_byteenable      (m1_byteenable),
        .m1_waitrequest     (m1_waitrequest),
        .m1_readdata        (m1_readdata),
        .m1_readdatavalid   (m1_readdatavalid),
        .s_address          (s_address),
        .s_read             (s_read),
        .s_write            (s_write),
        .s_writedata        (s_writedata),
        .s_byteenable       (s_byteenable),
        .s_waitrequest      (s_waitrequest),
        .s_readdata         (s_readdata),
        .s_readdatavalid    (s_readdatavalid),
        .err_unexpected_rdv (err_unexpected_rdv)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single read from one master with the controller ready.
    task automatic issue_read(input master_id_t id, input logic [AW-1:0] addr);
        if (id == M1) begin m1_read = 1'b1; m1_address = addr; end
        else          begin m0_read = 1'b1; m0_address = addr; end
        s_waitrequest = 1'b0;
        #2;
        chk("rd_s_read", 32'(s_read), 32'd1);
        chk("rd_s_addr", 32'(s_address), 32'(addr));
        chk("rd_wait", 32'((id == M1) ? m1_waitrequest : m0_waitrequest), 32'd0);
        exp_q.push_back(id);
        step();
        m0_read = 1'b0;
        m1_read = 1'b0;
    endtask

    // One response beat; routing checked against the scoreboard head.
    task automatic respond(input logic [DW-1:0] data);
        master_id_t id;
        s_readdatavalid = 1'b1;
        s_readdata      = data;
        #2;
        if (exp_q.size() > 0) begin
            id = exp_q.pop_front();
            chk("rdv_m0", 32'(m0_readdatavalid), 32'(id == M0));
            chk("rdv_m1", 32'(m1_readdatavalid), 32'(id == M1));
            chk("rdata", 32'((id == M1) ? m1_readdata : m0_readdata), 32'(data));
        end else begin
            chk("stray_m0", 32'(m0_readdatavalid), 32'd0);
            chk("stray_m1", 32'(m1_readdatavalid), 32'd0);
        end
        step();
        s_readdatavalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        master_id_t id;

        // Reset values
        #3;
        chk("rst_s_read", 32'(s_read), 32'd0);
        chk("rst_s_write", 32'(s_write), 32'd0);
        chk("rst_m0_wait", 32'(m0_waitrequest), 32'd1);
        chk("rst_m1_wait", 32'(m1_waitrequest), 32'd1);
        chk("rst_rdv", 32'({m0_readdatavalid, m1_readdatavalid}), 32'd0);
        chk("rst_err", 32'(err_unexpected_rdv), 32'd0);
        chk("rst_pend", 32'(dut.w_pend_cnt), 32'd0);
        chk("rst_rr", 32'(dut.r_rr), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Continuous writes from both masters alternate
        m0_write = 1'b1; m0_address = AW'(32'h10); m0_writedata = 16'hA0A0;
        m1_write = 1'b1; m1_address = AW'(32'h20); m1_writedata = 16'hB1B1;
        for (int i = 0; i < 4; i++) begin
            #2;
            chk("alt_m0_wait", 32'(m0_waitrequest), 32'(i % 2 != 0));
            chk("alt_m1_wait", 32'(m1_waitrequest), 32'(i % 2 == 0));
            chk("alt_addr", 32'(s_address), (i % 2 == 0) ? 32'h10 : 32'h20);
            chk("alt_wdata", 32'(s_writedata), (i % 2 == 0) ? 32'hA0A0 : 32'hB1B1);
            step();
        end
        m1_write = 1'b0;
        #2;
        chk("solo_m0_wait", 32'(m0_waitrequest), 32'd0);
        step();
        m0_write = 1'b0;
        chk("rr_after_solo", 32'(dut.r_rr), 32'd1);

        // Stall lock: rr points at m1, but stalled m0 keeps grant
        m0_write = 1'b1; m0_address = AW'(32'h000100);
        s_waitrequest = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (c >= 1) begin m1_write = 1'b1; m1_address = AW'(32'h000200); end
            #2;
            chk("lock_addr", 32'(s_address), 32'h100);
            chk("lock_write", 32'(s_write), 32'd1);
            chk("lock_m0_wait", 32'(m0_waitrequest), 32'd1);
            chk("lock_m1_wait", 32'(m1_waitrequest), 32'd1);
            step();
        end
        s_waitrequest = 1'b0;
        #2;
        chk("lock_acc_addr", 32'(s_address), 32'h100);
        chk("lock_acc_m0", 32'(m0_waitrequest), 32'd0);
        chk("lock_acc_m1", 32'(m1_waitrequest), 32'd1);
        step();
        m0_write = 1'b0;
        #2;
        chk("after_lock_addr", 32'(s_address), 32'h200);
        chk("after_lock_m1", 32'(m1_waitrequest), 32'd0);
        step();
        m1_write = 1'b0;

        // Read routing across masters
        issue_read(M0, AW'(32'hA));
        issue_read(M1, AW'(32'hB));
        issue_read(M0, AW'(32'hC));
        respond(16'h1111);
        respond(16'h2222);
        respond(16'h3333);
        chk("routing_pend", 32'(dut.w_pend_cnt), 32'd0);

        // Full-FIFO throttling
        for (int i = 0; i < 4; i++) issue_read(M1, AW'(32'h500 + 32'(i)));
        chk("full_pend", 32'(dut.w_pend_cnt), 32'd4);
        m1_read = 1'b1; m1_address = AW'(32'h505);
        m0_write = 1'b1; m0_address = AW'(32'h77);
        #2;
        chk("full_m1_wait", 32'(m1_waitrequest), 32'd1);
        chk("full_s_read", 32'(s_read), 32'd0);
        chk("full_s_write", 32'(s_write), 32'd1);
        chk("full_m0_wait", 32'(m0_waitrequest), 32'd0);
        chk("full_wr_addr", 32'(s_address), 32'h77);
        step();
        m0_write = 1'b0;
        s_readdatavalid = 1'b1; s_readdata = 16'hAAAA;
        #2;
        id = exp_q.pop_front();
        chk("full_pop_m1rdv", 32'(m1_readdatavalid), 32'(id == M1));
        chk("no_bypass_wait", 32'(m1_waitrequest), 32'd1);
        chk("no_bypass_sread", 32'(s_read), 32'd0);
        step();
        s_readdatavalid = 1'b0;
        #2;
        chk("5th_s_read", 32'(s_read), 32'd1);
        chk("5th_m1_wait", 32'(m1_waitrequest), 32'd0);
        chk("5th_addr", 32'(s_address), 32'h505);
        exp_q.push_back(M1);
        step();
        m1_read = 1'b0;
        chk("refull_pend", 32'(dut.w_pend_cnt), 32'd4);

        // Same-cycle push and pop at pend_cnt == 2
        respond(16'h0101);
        respond(16'h0202);
        chk("pp_pend_before", 32'(dut.w_pend_cnt), 32'd2);
        m0_read = 1'b1; m0_address = AW'(32'h600);
        s_readdatavalid = 1'b1; s_readdata = 16'hBEEF;
        #2;
        id = exp_q.pop_front();
        chk("pp_m0rdv", 32'(m0_readdatavalid), 32'(id == M0));
        chk("pp_m1rdv", 32'(m1_readdatavalid), 32'(id == M1));
        chk("pp_s_read", 32'(s_read), 32'd1);
        chk("pp_m0_wait", 32'(m0_waitrequest), 32'd0);
        exp_q.push_back(M0);
        step();
        m0_read = 1'b0;
        s_readdatavalid = 1'b0;
        chk("pp_pend_after", 32'(dut.w_pend_cnt), 32'd2);
        respond(16'h0303);
        respond(16'h0404);
        chk("drain_pend", 32'(dut.w_pend_cnt), 32'd0);
        chk("drain_q", 32'(exp_q.size()), 32'd0);

        // Unexpected response with nothing pending
        chk("pre_err", 32'(err_unexpected_rdv), 32'd0);
        respond(16'hDEAD);
        chk("err_set", 32'(err_unexpected_rdv), 32'd1);
        chk("err_pend", 32'(dut.w_pend_cnt), 32'd0);
        step();
        step();
        chk("err_sticky", 32'(err_unexpected_rdv), 32'd1);

        // Reset mid-operation with reads pending
        issue_read(M0, AW'(32'h700));
        issue_read(M1, AW'(32'h701));
        issue_read(M0, AW'(32'h702));
        chk("mid_pend", 32'(dut.w_pend_cnt), 32'd3);
        chk("mid_rr", 32'(dut.r_rr), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_pend", 32'(dut.w_pend_cnt), 32'd0);
        chk("arst_rr", 32'(dut.r_rr), 32'd0);
        chk("arst_err", 32'(err_unexpected_rdv), 32'd0);
        exp_q.delete();
        step();
        rst_n = 1'b1;
        step();
        respond(16'h4444);
        chk("post_rst_err", 32'(err_unexpected_rdv), 32'd1);
        chk("post_rst_pend", 32'(dut.w_pend_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Two-master Avalon-MM arbiter that shares the single SDRAM controller slave port in the softcore between the Nios data master (m0) and a second master such as a DMA or LED-pattern engine (m1). It arbitrates single-word transfers round-robin and forwards the winning command to the controller with zero added latency. It tracks pipelined read responses in an ID FIFO so each `readdatavalid` reaches the master that issued the read. It sits between the fabric masters and the SDRAM controller's Avalon slave, in the `clk_clk` domain.

## Interface
- `ADDR_W`, 22, word address width (4M x 16 SDRAM)
- `DATA_W`, 16, data width; byteenable width is `DATA_W/8`
- `MAX_PEND`, 4, maximum outstanding reads; power of two, 2..16
- Clocking and reset: one clock; reset is asynchronous and active-low.
- `clk_clk`  in  1  system clock
- `reset_reset_n`  in  1  asynchronous active-low reset
- `mN_address`  in  ADDR_W  master N address (N = 0, 1)
- `mN_read`, `mN_write`  in  1  master N command
- `mN_writedata`  in  DATA_W  master N write data
- `mN_byteenable`  in  DATA_W/8  master N byte enables
- `mN_waitrequest`  out  1  stall to master N
- `mN_readdata`  out  DATA_W  read data; `s_readdata` is broadcast to both masters
- `mN_readdatavalid`  out  1  read response for master N
- `s_address`, `s_read`, `s_write`, `s_writedata`, `s_byteenable`  out  the command to the SDRAM controller
- `s_waitrequest`, `s_readdata`, `s_readdatavalid`  in  the controller's response
- `err_unexpected_rdv`  out  1  sticky flag; set on `readdatavalid` while no read is pending

## Operation
- A master is requesting when `mN_read|mN_write`. A request is eligible unless it is a read while `pend_cnt == MAX_PEND`. Writes are always eligible.
- Grant is combinational from the eligible requests and the round-robin pointer `rr`. If both are eligible, the master selected by `rr` wins. If only one is eligible, it wins.
- Lock: once a command has been presented and `s_waitrequest=1`, grant is held on that master via `lock`/`lock_id` until acceptance. Rotation never occurs mid-stall, which keeps the Avalon hold rule intact.
- A transfer is accepted when `(s_read|s_write) & !s_waitrequest`. On acceptance, `rr` moves to the other master.
- Granted master: its command is muxed to `s_*` and `mN_waitrequest = s_waitrequest`.
- Non-granted or ineligible requester: `mN_waitrequest=1`.
- Idle master: `mN_waitrequest=1`. Avalon permits this.
- No grant: `s_read = s_write = 0`.
- An accepted read pushes the granted master ID into the tag FIFO.
- `s_readdatavalid` pops the FIFO head and asserts `mN_readdatavalid` for head ID N only.
- `pend_cnt` tracks FIFO occupancy. A push and a pop in the same cycle leave it unchanged.
- If `s_readdatavalid` arrives with the FIFO empty: the pulse is dropped, no master sees valid, `err_unexpected_rdv` is set, and the counter stays at 0.
- Reset values:
  - Outputs: `s_read = s_write = 0`, `mN_waitrequest = 1`, `mN_readdatavalid = 0`, `err_unexpected_rdv = 0`.
  - State: `rr = m0`, `lock = 0`, FIFO empty.
- Reset asserted mid-operation clears all state immediately. Outstanding reads are forgotten and later responses fall under the empty-FIFO rule.

## Timing
- Command path is combinational, with 0 added cycles. Acceptance takes the same cycle as the controller's `!s_waitrequest`.
- Response path is combinational: `mN_readdatavalid` rises in the same cycle as `s_readdatavalid`.
- `rr`, `lock`, the FIFO and `pend_cnt` all update on the rising edge of `clk_clk`.
- Full-FIFO read throttling takes effect in the cycle `pend_cnt` reaches `MAX_PEND`. The next read is eligible in the cycle after a pop. There is no same-cycle bypass.
- Read ordering per master and across masters equals acceptance order, as the controller guarantees.

## Structure
- Package `sdram_arb_pkg`:
  - `master_id_t` (1 bit)
  - `NUM_MASTERS = 2`
  - default `ADDR_W`, `DATA_W` and `MAX_PEND` constants
- Sub-module `arb_tag_fifo`: synchronous FIFO of `master_id_t` with depth `MAX_PEND`. It has push, pop, head, count, full and empty. Pointers wrap modulo `MAX_PEND`, and the count is `$clog2(MAX_PEND)+1` bits.
- Top level holds the grant logic, lock, `rr`, muxes and error flag.

## Test plan
- Both masters issue continuous writes with `s_waitrequest=0` -> acceptances alternate m0, m1, m0, m1, and each `mN_waitrequest` is low only on its turn.
- m0 writes to address 0x000100 while the controller holds `s_waitrequest=1` for 3 cycles and m1 requests meanwhile -> grant stays on m0 for all 3 cycles, `s_address=0x000100` is stable, and m1 is accepted in the cycle after m0.
- m0 reads A, m1 reads B, m0 reads C, and the controller returns 0x1111, 0x2222, 0x3333 -> `m0_readdatavalid` on beats 1 and 3, `m1_readdatavalid` on beat 2.
- With `MAX_PEND=4`, m1 issues 5 reads with no responses -> the 5th read stalls with `m1_waitrequest=1` and `s_read=0`. After one `s_readdatavalid`, the 5th read is accepted on the following cycle, and a write from m0 is accepted while the FIFO is full.
- Push and pop in the same cycle at `pend_cnt=2` -> `pend_cnt` stays 2 and routing stays correct.
- `s_readdatavalid` pulses with nothing pending -> no `mN_readdatavalid` and `err_unexpected_rdv=1` until reset.
- `reset_reset_n` asserted with 3 reads pending -> immediate `pend_cnt=0` and `rr=m0`, and a subsequent response sets `err_unexpected_rdv`.
